// File: rtl/rx_pkg.sv
// Shared definitions for the lane receiver / de-striper.
//   COM        : alignment/control symbol, never forwarded downstream
//   LOCK_CNT   : consecutive aligned COM sets needed to declare lock
//   ERR_MAX    : consecutive lane-mismatch boundaries that drop lock
//   MODE_*     : lane-mode encodings carried on the S input
//   rx_state_e : receiver state encoding (also exported for debug)
package rx_pkg;

    localparam logic [7:0] COM      = 8'hBC;
    localparam int         LOCK_CNT = 2;
    localparam int         ERR_MAX  = 3;

    localparam logic [1:0] MODE_X1 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X4 = 2'b10;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    // Lanes taking part in a mode; the reserved code behaves as x1.
    function automatic logic [3:0] lane_mask(input logic [1:0] mode);
        case (mode)
            MODE_X1: return 4'b0001;
            MODE_X2: return 4'b0011;
            MODE_X4: return 4'b1111;
            default: return 4'b0001;
        endcase
    endfunction

    // Bytes drained per data set in a mode.
    function automatic logic [2:0] lane_count(input logic [1:0] mode);
        case (mode)
            MODE_X2: return 3'd2;
            MODE_X4: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/rx_lane.sv
// One serial lane: MSB-first shift register plus COM detector.
//   clk, reset (async, active low), enb : clock / reset / enable
//   ln     : serial lane input
//   sym    : current 8-bit window including the bit arriving this cycle
//   is_com : sym equals COM
module rx_lane
    import rx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic       ln,
    output logic [7:0] sym,
    output logic       is_com
);

    // The 8-bit shift register is {hist, ln}: only the seven older bits need
    // storage, since the oldest bit ages out on the very next shift.
    logic [6:0] hist;

    assign sym    = {hist, ln};
    assign is_com = (sym == COM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
        end else if (enb) begin
            hist <= sym[6:0];
        end
    end

endmodule

// File: rtl/rx_destripe.sv
// Receive-side lane de-striper: finds symbol lock on COM across the active
// lanes, then drains each data set as a byte stream in lane order.
//   clk, reset (async, active low), enb (freeze when 0)
//   S          : lane mode, latched when lock is declared
//   L0..L3     : serial lanes, MSB first
//   data/valid : output byte and its qualifier. valid is a pure strobe with
//                no ready: the consumer must take every byte the cycle it is
//                valid; data holds its last value while valid is low.
//   locked     : symbol lock achieved
//   err        : one-cycle pulse on a partial-COM boundary while locked
//   dbg_state  : current FSM state
module rx_destripe
    import rx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic [1:0] S,
    input  logic       L0,
    input  logic       L1,
    input  logic       L2,
    input  logic       L3,
    output logic [7:0] data,
    output logic       valid,
    output logic       locked,
    output logic       err,
    output rx_state_e  dbg_state
);

    rx_state_e  state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [1:0] lock_cnt, lock_cnt_n;
    logic [1:0] err_cnt, err_cnt_n;
    logic [1:0] mode_q;
    logic       latch_buf, latch_mode, err_n;

    logic [3:0] lane_in;
    logic [7:0] sym [4];
    logic [3:0] is_com;

    logic [7:0] hold [4];
    logic [2:0] drain_rem;
    logic [1:0] drain_idx;

    assign lane_in   = {L3, L2, L1, L0};
    assign dbg_state = state;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        rx_lane u_lane (
            .clk    (clk),
            .reset  (reset),
            .enb    (enb),
            .ln     (lane_in[i]),
            .sym    (sym[i]),
            .is_com (is_com[i])
        );
    end

    // While hunting/verifying the live S picks the lanes; once locked the
    // latched mode is used so S changes have no effect until the next hunt.
    logic [1:0] act_mode;
    logic [3:0] mask;
    logic       all_com, none_com, boundary;

    assign act_mode = (state == LOCKED) ? mode_q : S;
    assign mask     = lane_mask(act_mode);
    assign all_com  = ((is_com & mask) == mask);
    assign none_com = ((is_com & mask) == 4'b0000);
    // bit_cnt==7 is the cycle the eighth bit of a symbol is sampled.
    assign boundary = (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            bit_cnt  <= '0;
            lock_cnt <= '0;
            err_cnt  <= '0;
            mode_q   <= MODE_X1;
        end else if (enb) begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            lock_cnt <= lock_cnt_n;
            err_cnt  <= err_cnt_n;
            if (latch_mode) begin
                mode_q <= S;
            end
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt + 3'd1;
        lock_cnt_n = lock_cnt;
        err_cnt_n  = err_cnt;
        latch_buf  = 1'b0;
        latch_mode = 1'b0;
        err_n      = 1'b0;
        case (state)
            HUNT: begin
                // A match marks this cycle as the boundary (count restarts at 0).
                bit_cnt_n  = 3'd0;
                lock_cnt_n = 2'd0;
                err_cnt_n  = 2'd0;
                if (all_com) begin
                    state_n    = VERIFY;
                    lock_cnt_n = 2'd1;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (all_com) begin
                        lock_cnt_n = lock_cnt + 2'd1;
                        if (lock_cnt_n == 2'(LOCK_CNT)) begin
                            state_n    = LOCKED;
                            latch_mode = 1'b1;
                        end
                    end else begin
                        state_n    = HUNT;
                        lock_cnt_n = 2'd0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (all_com) begin
                        err_cnt_n = 2'd0;
                    end else if (none_com) begin
                        err_cnt_n = 2'd0;
                        latch_buf = 1'b1;
                    end else begin
                        err_n = 1'b1;
                        if (err_cnt == 2'(ERR_MAX - 1)) begin
                            state_n   = HUNT;
                            err_cnt_n = 2'd0;
                        end else begin
                            err_cnt_n = err_cnt + 2'd1;
                        end
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    // Output side: the hold buffer is loaded at the boundary and drained one
    // byte per enabled cycle starting on the next edge. A drain (max 4) always
    // ends before the next boundary (8 cycles), so the buffer never overruns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            drain_rem <= '0;
            drain_idx <= '0;
            for (int i = 0; i < 4; i++) begin
                hold[i] <= 8'h00;
            end
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (enb) begin
                err    <= err_n;
                locked <= (state_n == LOCKED);
                if (latch_buf) begin
                    for (int i = 0; i < 4; i++) begin
                        hold[i] <= sym[i];
                    end
                    drain_rem <= lane_count(mode_q);
                    drain_idx <= 2'd0;
                end else if (drain_rem != 3'd0) begin
                    data      <= hold[drain_idx];
                    valid     <= 1'b1;
                    drain_idx <= drain_idx + 2'd1;
                    drain_rem <= drain_rem - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_destripe.sv
// Bench for rx_destripe: random lane symbol sets, expected byte stream built
// from the lane-mode rules and stamped with the cycle each byte is due.
module tb_rx_destripe;
    import rx_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enb = 1'b0;
    logic [1:0] S = 2'b00;
    logic       L0 = 1'b0, L1 = 1'b0, L2 = 1'b0, L3 = 1'b0;
    logic [7:0] data;
    logic       valid, locked, err;
    rx_state_e  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_seen = 0;

    // {cycle stamp, byte}
    logic [39:0] exp_q[$];
    logic [39:0] obs_q[$];

    rx_destripe dut (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .S         (S),
        .L0        (L0),
        .L1        (L1),
        .L2        (L2),
        .L3        (L3),
        .data      (data),
        .valid     (valid),
        .locked    (locked),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid) obs_q.push_back({32'(cyc), data});
        if (err) err_seen = err_seen + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; enb = 1'b0;
        L0 = 1'b0; L1 = 1'b0; L2 = 1'b0; L3 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; enb = 1'b1;
    endtask

    // Drives one 8-bit symbol per lane (lane i = w[8i+:8]), MSB first.
    // bnd is the cycle stamp of the edge that samples the eighth bit.
    task automatic drive_set(input logic [31:0] w, output int bnd);
        for (int k = 7; k >= 0; k--) begin
            @(negedge clk);
            L0 = w[k]; L1 = w[8+k]; L2 = w[16+k]; L3 = w[24+k];
        end
        bnd = cyc + 1;
    endtask

    // Active lanes get COM (com=1) or random non-COM bytes; others are random.
    function automatic logic [31:0] mk_set(input int nact, input bit com);
        logic [31:0] w;
        logic [7:0]  b;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            if (i < nact) begin
                if (com) b = COM;
                else while (b == COM) b = 8'($urandom);
            end
            w[8*i +: 8] = b;
        end
        return w;
    endfunction

    function automatic int lanes_of(input logic [1:0] mode);
        if (mode == 2'b10) return 4;
        if (mode == 2'b01) return 2;
        return 1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; enb = 1'b1; S = 2'b10;
        L0 = 1'b1; L1 = 1'b0; L2 = 1'b1; L3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (dbg_state !== HUNT) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, HUNT); end
    endtask

    // Lock in a mode, then stream a fixed set followed by random data/skip sets.
    task automatic test_destripe(input logic [1:0] mode, input logic [31:0] first, input int n_rand);
        int nact, bnd, e0;
        logic [31:0] w;
        logic [39:0] got, want;
        bit skip;
        nact = lanes_of(mode);
        do_reset();
        S = mode;
        exp_q.delete(); obs_q.delete();
        e0 = err_seen;
        drive_set(mk_set(nact, 1), bnd);
        @(posedge clk); #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early mode=%b got %b want 0", mode, locked); end
        drive_set(mk_set(nact, 1), bnd);
        @(posedge clk); #1;
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_2nd mode=%b got %b want 1", mode, locked); end
        S = 2'($urandom_range(0, 3));
        for (int i = 0; i <= n_rand; i++) begin
            skip = 1'b0;
            if (i == 0) w = first;
            else if ($urandom_range(0, 3) == 0) begin w = mk_set(nact, 1); skip = 1'b1; end
            else w = mk_set(nact, 0);
            drive_set(w, bnd);
            if (!skip)
                for (int k = 0; k < nact; k++) exp_q.push_back({32'(bnd + 1 + k), w[8*k +: 8]});
        end
        drive_set(mk_set(nact, 1), bnd);
        @(posedge clk); #1;
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_hold mode=%b got %b want 1", mode, locked); end
        checks++; if (err_seen != e0) begin errors++; $display("FAIL stream_err mode=%b got %0d pulses want 0", mode, err_seen - e0); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL stream_len mode=%b got %0d want %0d", mode, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            want = exp_q.pop_front(); got = obs_q.pop_front();
            checks++;
            if (got !== want)
                begin errors++; $display("FAIL stream_byte mode=%b got cyc %0d %h want cyc %0d %h",
                                         mode, got[39:8], got[7:0], want[39:8], want[7:0]); end
        end
    endtask

    task automatic test_skip_mismatch();
        int bnd, run, e0;
        bit exp_locked;
        bit is_mm [7] = '{0, 1, 1, 0, 1, 1, 1};
        logic [31:0] w;
        do_reset();
        S = 2'b10;
        drive_set(mk_set(4, 1), bnd);
        drive_set(mk_set(4, 1), bnd);
        obs_q.delete();
        e0 = err_seen; run = 0; exp_locked = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (is_mm[i]) begin w = mk_set(4, 0); w[7:0] = COM; run++; end
            else begin w = mk_set(4, 1); run = 0; end
            if (run >= ERR_MAX) exp_locked = 1'b0;
            drive_set(w, bnd);
            @(posedge clk); #1;
            checks++; if (err !== is_mm[i]) begin errors++; $display("FAIL mm_err set=%0d got %b want %b", i, err, is_mm[i]); end
            checks++; if (locked !== exp_locked) begin errors++; $display("FAIL mm_locked set=%0d got %b want %b", i, locked, exp_locked); end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (err_seen - e0 != 5) begin errors++; $display("FAIL mm_pulses got %0d want 5", err_seen - e0); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mm_valid got %0d bytes want 0", obs_q.size()); end
    endtask

    task automatic test_misaligned();
        logic [23:0] s0, s1;
        int bad, e0;
        do_reset();
        S = 2'b01;
        s0 = {COM, 16'h0000};
        s1 = {1'b0, COM, 15'h0000};
        bad = 0; e0 = err_seen;
        for (int k = 23; k >= 0; k--) begin
            @(negedge clk);
            L0 = s0[k]; L1 = s1[k]; L2 = 1'($urandom); L3 = 1'($urandom);
            @(posedge clk); #1;
            if (locked !== 1'b0 || dbg_state !== HUNT) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL misalign_lock got %0d bad cycles want 0", bad); end
        checks++; if (err_seen != e0) begin errors++; $display("FAIL misalign_err got %0d pulses want 0", err_seen - e0); end
    endtask

    task automatic test_enb_freeze();
        int bnd, bad;
        logic [31:0] w;
        do_reset();
        S = 2'b10;
        drive_set(mk_set(4, 1), bnd);
        drive_set(mk_set(4, 1), bnd);
        w = mk_set(4, 0);
        drive_set(w, bnd);
        @(posedge clk);
        @(posedge clk); #1;
        checks++; if (valid !== 1'b1 || data !== w[7:0]) begin errors++; $display("FAIL freeze_first got %b/%h want 1/%h", valid, data, w[7:0]); end
        @(negedge clk); enb = 1'b0;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (valid !== 1'b0 || data !== w[7:0]) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL freeze_hold got %0d bad cycles want 0", bad); end
        @(negedge clk); enb = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (valid !== 1'b1 || data !== w[8*k +: 8])
                begin errors++; $display("FAIL freeze_resume lane=%0d got %b/%h want 1/%h", k, valid, data, w[8*k +: 8]); end
        end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL freeze_end got %b want 0", valid); end
    endtask

    task automatic test_reset_mid_drain();
        int bnd;
        logic [31:0] w;
        do_reset();
        S = 2'b10;
        drive_set(mk_set(4, 1), bnd);
        drive_set(mk_set(4, 1), bnd);
        w = mk_set(4, 0);
        drive_set(w, bnd);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b1 || data !== w[15:8]) begin errors++; $display("FAIL drain_2nd got %b/%h want 1/%h", valid, data, w[15:8]); end
        #1 reset = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", valid); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL async_data got %h want 00", data); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL async_locked got %b want 0", locked); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_destripe(2'b10, 32'h04030201, 8);
        test_destripe(2'b01, {16'($urandom), 16'h0DE6}, 8);
        test_destripe(2'b00, mk_set(1, 0), 6);
        test_destripe(2'b11, mk_set(1, 0), 6);
        test_skip_mismatch();
        test_misaligned();
        test_enb_freeze();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_destripe.md
Name: rx_destripe

Overview:
- Receive-side counterpart of the lane transmitter.
- Samples up to four serial lanes (L0..L3) on the bit clock, MSB first.
- Achieves symbol lock on the COM byte and de-stripes lane bytes back into a single byte stream with a valid strobe.
- Sits between the lane PHY model and the link-layer consumer.

Parameters:
- COM, 8'hBC, alignment/control symbol; dropped from the output stream.
- LOCK_CNT, 2, consecutive boundary-aligned COM sets required to declare lock.
- ERR_MAX, 3, consecutive lane-mismatch boundaries that force loss of lock.

Ports:
- clk  in  1  bit clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- enb  in  1  receiver enable; when 0, state holds and no output is produced.
- S  in  2  lane mode: 00=x1 (L0), 01=x2 (L0,L1), 10=x4 (L0..L3), 11=reserved, treated as x1. Latched on entry to LOCKED.
- L0, L1, L2, L3  in  1 each  serial lane inputs.
- data  out  8  de-striped byte.
- valid  out  1  data qualifier, one byte per cycle.
- locked  out  1  symbol lock achieved.
- err  out  1  one-cycle pulse on a lane mismatch at a symbol boundary.

Behaviour:
- Reset (reset=0, asynchronous): state=HUNT; all shift registers=0; bit counter=0; lock and error counters=0; data=8'h00; valid=0; locked=0; err=0. Any in-flight drain is discarded.
- Per lane: 8-bit shift register, sr <= {sr[6:0], Ln} each enabled cycle. Only lanes active in the current mode participate.
- HUNT:
  - Each cycle, compare every active lane's sr (including the bit shifted in this cycle) against COM.
  - If all active lanes match in the same cycle: set bit counter=0 as the boundary, lock count=1, go to VERIFY.
  - A partial match (some lanes match, not all) stays in HUNT with no err.
- VERIFY:
  - The bit counter counts 0..7 and wraps. At each wrap (boundary), all active lanes must equal COM.
  - If they do, lock count increments; on reaching LOCK_CNT, go to LOCKED, latch S, and set locked=1 in the same cycle the state changes.
  - Any non-COM symbol at a boundary returns to HUNT with lock count=0.
- LOCKED, at each boundary:
  - All active lanes == COM: skip set. Nothing is output; the error counter clears.
  - No active lane == COM: data symbols. Latch them into a 4-entry hold buffer in lane order (L0 first). The error counter clears.
  - Some but not all lanes == COM: err=1 for one cycle, nothing is output, error counter +1. When the counter reaches ERR_MAX, go to HUNT with locked=0 on the next cycle.
- Drain:
  - Starting the cycle after the boundary, output buffered bytes one per cycle with valid=1: 1, 2 or 4 cycles for x1, x2 or x4.
  - Bytes appear in lane order, so a byte from L0 precedes L1, and so on.
  - Drain always finishes within 4 cycles, before the next boundary (8 cycles), so no back-pressure or overflow is possible.
  - When valid=0, data holds its last value.
- Latency: the L0 byte appears on data exactly 1 clk after the cycle its 8th bit is sampled.
- enb=0: shifting, counters and drain all freeze; valid=0 while frozen. Drain resumes when enb returns to 1.
- S changes while LOCKED are ignored until the next HUNT.
- reset asserted mid-drain: output clears immediately (asynchronously).

Decomposition:
- Package rx_pkg:
  - COM constant.
  - Mode encodings: MODE_X1=2'b00, MODE_X2=2'b01, MODE_X4=2'b10.
  - State encoding: HUNT, VERIFY, LOCKED.
- Sub-module rx_lane, instantiated ×4:
  - Contents: the 8-bit shift register, the is_com compare output, and the byte output.
  - The top level holds the FSM, bit counter, lock/error counters, hold buffer and drain counter.

Test Plan:
1. Reset then lock, x4: reset=0 for 2 cycles, then S=10, enb=1. Drive COM on all four lanes for two consecutive 8-bit symbols. Expect locked=1 at the 2nd boundary, and valid stays 0.
2. Data de-stripe, x4: after lock, drive 8'h01, 8'h02, 8'h03, 8'h04 on L0..L3. Expect data 01, 02, 03, 04 with valid=1 on 4 consecutive cycles, starting 1 clk after the boundary.
3. x2 mode: S=01, lock, then drive 8'hE6 on L0 and 8'h0D on L1. Expect E6 then 0D, valid=1 for exactly 2 cycles; L2/L3 toggling is ignored.
4. Skip and mismatch: while locked in x4, send an all-COM set and expect no valid. Then send COM on L0 only for 3 consecutive symbols: expect err to pulse 3 times, and locked=0 after the 3rd.
5. Misaligned hunt: COM on L0 one bit earlier than on L1 in x2 mode. Expect no lock and no err; locked stays 0.
6. Async reset mid-drain: assert reset during the 2nd valid cycle of an x4 drain. Expect valid=0, data=00 and locked=0 immediately, without waiting for a clk edge.
